// File: rtl/chram_wr_arbiter.sv
// Character-RAM write arbiter: round-robin burst ownership among three requesters.
// Optional vertical-blank write gating is enabled with the CHRAM_VBLANK_GATE_EN macro.
module chram_wr_arbiter #(
    parameter int         NREQ      = 3,
    parameter int         MAX_BURST = 16,
    parameter logic [9:0] VBL_LINE  = 10'd480
) (
    input  logic                i_clk,
    input  logic                reset_n,
    input  logic [9:0]          vcnt,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     last,
    input  logic [11*NREQ-1:0]  addr,
    input  logic [8*NREQ-1:0]   data,
    output logic [NREQ-1:0]     gnt,
    output logic                wr_ena,
    output logic [10:0]         wr_addr,
    output logic [7:0]          wr_data,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [2:0]      hold_q, hold_d;
    logic            wr_ena_q;
    logic [10:0]     wr_addr_q;
    logic [7:0]      wr_data_q;

    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   win;
    logic            found;
    logic            permit;
    logic [10:0]     sel_addr;
    logic [7:0]      sel_data;

`ifdef CHRAM_VBLANK_GATE_EN
    assign permit = (vcnt >= VBL_LINE);
`else
    logic unused_vcnt;
    assign permit      = 1'b1;
    assign unused_vcnt = ^{vcnt, VBL_LINE};
`endif

    function automatic logic [PW-1:0] next_of(input logic [PW-1:0] o);
        if (int'(o) == NREQ - 1) return '0;
        return o + PW'(1);
    endfunction

    // Handshake: a requester holds req/addr/data/last stable until it sees its gnt
    // bit; gnt is the combinational accept and the write follows one cycle later.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        hold_d   = hold_q;
        gnt_c    = '0;
        win      = rr_ptr_q;
        found    = 1'b0;

        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end

        case (state_q)
            IDLE: begin
                if (permit && found) begin
                    gnt_c[win] = 1'b1;
                    if (last[win] || MAX_BURST <= 1) begin
                        rr_ptr_d = next_of(win);
                    end else begin
                        state_d = BURST;
                        owner_d = win;
                        beat_d  = BW'(1);
                    end
                end
            end
            BURST, HOLD: begin
                // With permit low the burst is frozen: no beats, no HOLD timeout.
                if (permit) begin
                    if (req[owner_q]) begin
                        gnt_c[owner_q] = 1'b1;
                        hold_d         = '0;
                        if (last[owner_q] || (beat_q + BW'(1)) == BW'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_of(owner_q);
                            beat_d   = '0;
                        end else begin
                            state_d = BURST;
                            beat_d  = beat_q + BW'(1);
                        end
                    end else if (state_q == BURST) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else if (hold_q == 3'd3) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_of(owner_q);
                        beat_d   = '0;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_addr = addr[11*i +: 11];
                sel_data = data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            hold_q    <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            hold_q   <= hold_d;
            wr_ena_q <= |gnt_c;
            if (|gnt_c) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    // Gating with reset keeps gnt low while reset is held even if req is high.
    assign gnt       = gnt_c & {NREQ{reset_n}};
    assign wr_ena    = wr_ena_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/chram_wr_arbiter.md
CHRAM_WR_ARBITER -- requirements
Module: chram_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write requesters (fixed 3; 0 gear, 1 progress bar, 2 text).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum consecutive beats one requester may hold the port.
REQ-003 SHALL have parameter VBL_LINE, default 10'd480, first vcnt line of the write-permit window.
REQ-004 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vcnt, input, 10, current video line.
REQ-007 SHALL have port req, input, 3, per-requester write request.
REQ-008 SHALL have port last, input, 3, per-requester final-beat flag, valid with req.
REQ-009 SHALL have port addr, input, 33, three 11-bit addresses; requester i uses bits [11i+10:11i].
REQ-010 SHALL have port data, input, 24, three 8-bit data bytes; requester i uses bits [8i+7:8i].
REQ-011 SHALL have port gnt, output, 3, one-hot beat-accept pulse.
REQ-012 SHALL have port wr_ena, output, 1, character RAM write enable.
REQ-013 SHALL have port wr_addr, output, 11, character RAM write address.
REQ-014 SHALL have port wr_data, output, 8, character RAM write data.
REQ-015 SHALL have port busy, output, 1, high while state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, BURST, HOLD.
REQ-017 IDLE: when any req and permit high, SHALL grant by round-robin starting at rr_ptr, pulse gnt for the winner, go to BURST (or stay IDLE if winner's last is high).
REQ-018 BURST: owner's req and permit high -> gnt pulse each cycle; beat count increments; last high -> IDLE.
REQ-019 BURST: owner's req low -> HOLD; other requesters SHALL NOT be granted while in HOLD.
REQ-020 HOLD: owner's req returns high -> resume beats in BURST; HOLD longer than 4 cycles -> forced release to IDLE.
REQ-021 Beat count reaching MAX_BURST SHALL force release to IDLE after that beat regardless of last.
REQ-022 On every release rr_ptr SHALL become (owner+1) mod 3.
REQ-023 A gnt pulse in cycle N SHALL produce wr_ena=1 with the accepted addr/data in cycle N+1; latency exactly 1.
REQ-024 wr_ena SHALL be 0 in any cycle following a cycle with no gnt.
REQ-025 gnt SHALL be at most one-hot; never asserted for a requester with req low.
REQ-026 Requester SHALL hold addr, data, last stable while req high and gnt low.
REQ-027 Simultaneous requests in IDLE SHALL resolve round-robin; no requester waits longer than 2 bursts.
REQ-028 Owner dropping req and asserting another requester's req in the same cycle SHALL NOT change owner until release.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, rr_ptr=0, beat count 0, gnt=0, wr_ena=0, wr_addr=0, wr_data=0, busy=0.
REQ-030 Reset mid-burst SHALL abandon the burst; no write SHALL occur in the cycle after reset release.

Configuration
REQ-031 Macro CHRAM_VBLANK_GATE_EN defined: permit = (vcnt >= VBL_LINE); no gnt issued while permit low; active burst pauses (as HOLD without timeout) until permit returns.
REQ-032 Macro undefined: permit constant 1; vcnt unused.

Verification
REQ-033 Reset, req=3'b001, last=1, addr0=331, data0=8'h2A -> gnt=001 cycle 1, wr_ena=1 wr_addr=331 wr_data=2A cycle 2.
REQ-034 req=3'b111 all last=1 from rr_ptr=0 -> gnt sequence 001,010,100, then rr_ptr=0.
REQ-035 req1 burst 16 beats addr 136..151, last only on beat 16 -> 16 consecutive writes, then release; req0 pending granted next.
REQ-036 req1 burst 20 beats no last, MAX_BURST=16 -> forced release after beat 16; req1 regranted after other pending requesters.
REQ-037 Owner drops req 5 cycles mid-burst -> forced release after 4 HOLD cycles; waiting req2 granted.
REQ-038 With CHRAM_VBLANK_GATE_EN, vcnt=100, req0 high -> no gnt; vcnt=480 -> gnt in same cycle.
